vector_writeback: RTL and testbench

- Write-back stage feeding the Decode register-file write ports (pixel and multiplication banks) and the write-only output memory (WOM).
- Takes one 4-lane result bundle per transaction from the execute stage.
- Pulses the pixel/mul register write enables with lane data.
- When `wr_wom` is set, serializes the 4 lanes as saturated 8-bit pixels into WOM under a valid/ready handshake.

---
 rtl/vector_writeback_if.sv | 43 ++++
 rtl/vector_writeback.sv | 168 ++++++++++++++++
 tb/tb_vector_writeback.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_writeback_if.sv
// rtl/vector_writeback_if.sv - execute-side bundle, Decode write ports and WOM port of the write-back stage
interface vector_writeback_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int PIX_W  = 8
);
    logic              valid_in;
    logic              in_ready;
    logic [DATA_W-1:0] res1, res2, res3, res4;
    logic              wr_pxl;
    logic              wr_mul_reg;
    logic              wr_pos;
    logic              wr_mul_pos;
    logic              wr_wom;
    logic [ADDR_W-1:0] wom_addr;

    logic              we_pxl;
    logic              wr_pos_pxl;
    logic [DATA_W-1:0] wdp1, wdp2, wdp3, wdp4;
    logic              we_mul;
    logic              wr_mul_pos_in;
    logic [DATA_W-1:0] wdm1, wdm2, wdm3, wdm4;

    logic              wom_we;
    logic              wom_ready;
    logic [ADDR_W-1:0] wom_waddr;
    logic [PIX_W-1:0]  wom_wdata;
    logic              done;

    modport slave (
        input  valid_in, res1, res2, res3, res4, wr_pxl, wr_mul_reg, wr_pos, wr_mul_pos,
               wr_wom, wom_addr, wom_ready,
        output in_ready, we_pxl, wr_pos_pxl, wdp1, wdp2, wdp3, wdp4, we_mul, wr_mul_pos_in,
               wdm1, wdm2, wdm3, wdm4, wom_we, wom_waddr, wom_wdata, done
    );

    modport master (
        output valid_in, res1, res2, res3, res4, wr_pxl, wr_mul_reg, wr_pos, wr_mul_pos,
               wr_wom, wom_addr, wom_ready,
        input  in_ready, we_pxl, wr_pos_pxl, wdp1, wdp2, wdp3, wdp4, we_mul, wr_mul_pos_in,
               wdm1, wdm2, wdm3, wdm4, wom_we, wom_waddr, wom_wdata, done
    );
endinterface

// File: rtl/vector_writeback.sv
// rtl/vector_writeback.sv - write-back stage: register-bank write pulses and saturated 4-beat WOM store
module vector_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int PIX_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    vector_writeback_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REG, WOM} state_t;

    state_t            state, state_nxt;
    logic [1:0]        beat, beat_nxt;
    logic              accept;
    logic [DATA_W-1:0] lane_in [4];
    logic [DATA_W-1:0] res_q   [4];

    logic              in_ready_q, in_ready_nxt;
    logic              we_pxl_q, we_pxl_nxt, pos_pxl_q, pos_pxl_nxt;
    logic              we_mul_q, we_mul_nxt, pos_mul_q, pos_mul_nxt;
    logic [DATA_W-1:0] wdp_q [4];
    logic [DATA_W-1:0] wdp_nxt [4];
    logic [DATA_W-1:0] wdm_q [4];
    logic [DATA_W-1:0] wdm_nxt [4];
    logic              wom_we_q, wom_we_nxt;
    logic [ADDR_W-1:0] waddr_q, waddr_nxt;
    logic [PIX_W-1:0]  wdata_q, wdata_nxt;
    logic              done_q, done_nxt;

    // Negative clamps to 0; any set bit above the pixel field (sign clear) clamps to all-ones.
    function automatic logic [PIX_W-1:0] sat(input logic [DATA_W-1:0] v);
        if (v[DATA_W-1])
            sat = '0;
        else if (|v[DATA_W-2:PIX_W])
            sat = '1;
        else
            sat = v[PIX_W-1:0];
    endfunction

    assign lane_in[0] = bus.res1;
    assign lane_in[1] = bus.res2;
    assign lane_in[2] = bus.res3;
    assign lane_in[3] = bus.res4;
    assign accept     = (state == IDLE) && bus.valid_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= 2'd0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        case (state)
            IDLE: if (bus.valid_in) begin
                state_nxt = bus.wr_wom ? WOM : REG;
                beat_nxt  = 2'd0;
            end
            REG:  state_nxt = IDLE;
            WOM:  if (bus.wom_ready) begin
                beat_nxt = beat + 2'd1;
                if (beat == 2'd3)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_nxt = (state_nxt == IDLE);
        we_pxl_nxt   = 1'b0;
        we_mul_nxt   = 1'b0;
        done_nxt     = 1'b0;
        pos_pxl_nxt  = pos_pxl_q;
        pos_mul_nxt  = pos_mul_q;
        wdp_nxt      = wdp_q;
        wdm_nxt      = wdm_q;
        wom_we_nxt   = wom_we_q;
        waddr_nxt    = waddr_q;
        wdata_nxt    = wdata_q;
        case (state)
            IDLE: if (bus.valid_in) begin
                if (bus.wr_pxl) begin
                    we_pxl_nxt  = 1'b1;
                    pos_pxl_nxt = bus.wr_pos;
                    wdp_nxt     = lane_in;
                end
                if (bus.wr_mul_reg) begin
                    we_mul_nxt  = 1'b1;
                    pos_mul_nxt = bus.wr_mul_pos;
                    wdm_nxt     = lane_in;
                end
                // The first WOM beat overlaps the register pulse.
                if (bus.wr_wom) begin
                    wom_we_nxt = 1'b1;
                    waddr_nxt  = bus.wom_addr;
                    wdata_nxt  = sat(lane_in[0]);
                end else begin
                    done_nxt = 1'b1;
                end
            end
            WOM: if (bus.wom_ready) begin
                if (beat == 2'd3) begin
                    wom_we_nxt = 1'b0;
                    done_nxt   = 1'b1;
                end else begin
                    waddr_nxt = waddr_q + ADDR_W'(1);
                    wdata_nxt = sat(res_q[beat + 2'd1]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept)
            res_q <= lane_in;
        if (rst) begin
            in_ready_q <= 1'b1;
            we_pxl_q   <= 1'b0;
            pos_pxl_q  <= 1'b0;
            we_mul_q   <= 1'b0;
            pos_mul_q  <= 1'b0;
            wdp_q      <= '{default: '0};
            wdm_q      <= '{default: '0};
            wom_we_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            in_ready_q <= in_ready_nxt;
            we_pxl_q   <= we_pxl_nxt;
            pos_pxl_q  <= pos_pxl_nxt;
            we_mul_q   <= we_mul_nxt;
            pos_mul_q  <= pos_mul_nxt;
            wdp_q      <= wdp_nxt;
            wdm_q      <= wdm_nxt;
            wom_we_q   <= wom_we_nxt;
            waddr_q    <= waddr_nxt;
            wdata_q    <= wdata_nxt;
            done_q     <= done_nxt;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.we_pxl        = we_pxl_q;
    assign bus.wr_pos_pxl    = pos_pxl_q;
    assign bus.wdp1          = wdp_q[0];
    assign bus.wdp2          = wdp_q[1];
    assign bus.wdp3          = wdp_q[2];
    assign bus.wdp4          = wdp_q[3];
    assign bus.we_mul        = we_mul_q;
    assign bus.wr_mul_pos_in = pos_mul_q;
    assign bus.wdm1          = wdm_q[0];
    assign bus.wdm2          = wdm_q[1];
    assign bus.wdm3          = wdm_q[2];
    assign bus.wdm4          = wdm_q[3];
    assign bus.wom_we        = wom_we_q;
    assign bus.wom_waddr     = waddr_q;
    assign bus.wom_wdata     = wdata_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_vector_writeback.sv
// tb/tb_vector_writeback.sv - bench for vector_writeback: queue-level reference model, directed and random bundles
module tb_vector_writeback;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int PIX_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vector_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus();
    vector_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit rand_mode = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } beat_t;

    // Model: outputs expected after the most recent edge, plus pending WOM beats.
    bit          chk_en = 1'b0;
    bit          m_accepted = 1'b0;
    logic        m_in_ready, m_we_pxl, m_pos_pxl, m_we_mul, m_pos_mul, m_wom_we, m_done;
    logic [31:0] m_wdp [4];
    logic [31:0] m_wdm [4];
    logic [31:0] m_waddr;
    logic [7:0]  m_wdata;
    beat_t       beats [$];

    function automatic logic [7:0] pix(input logic [31:0] r);
        int v;
        v = $signed(r);
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [31:0] r [4];
        r = '{bus.res1, bus.res2, bus.res3, bus.res4};
        if (rst) begin
            chk_en     = 1'b1;
            m_accepted = 1'b0;
            m_in_ready = 1'b1;
            {m_we_pxl, m_pos_pxl, m_we_mul, m_pos_mul, m_wom_we, m_done} = '0;
            m_wdp   = '{default: '0};
            m_wdm   = '{default: '0};
            m_waddr = '0;
            m_wdata = '0;
            beats.delete();
        end else begin
            m_accepted = 1'b0;
            m_we_pxl   = 1'b0;
            m_we_mul   = 1'b0;
            m_done     = 1'b0;
            if (!m_in_ready) begin
                if (beats.size() > 0) begin
                    if (bus.wom_ready) begin
                        void'(beats.pop_front());
                        if (beats.size() == 0) begin
                            m_wom_we   = 1'b0;
                            m_done     = 1'b1;
                            m_in_ready = 1'b1;
                        end else begin
                            m_waddr = beats[0].addr;
                            m_wdata = beats[0].data;
                        end
                    end
                end else begin
                    m_in_ready = 1'b1;
                end
            end else if (bus.valid_in) begin
                m_accepted = 1'b1;
                m_in_ready = 1'b0;
                if (bus.wr_pxl) begin
                    m_we_pxl = 1'b1; m_pos_pxl = bus.wr_pos; m_wdp = r;
                end
                if (bus.wr_mul_reg) begin
                    m_we_mul = 1'b1; m_pos_mul = bus.wr_mul_pos; m_wdm = r;
                end
                if (bus.wr_wom) begin
                    for (int k = 0; k < 4; k++)
                        beats.push_back('{addr: 32'(bus.wom_addr + 32'(k)), data: pix(r[k])});
                    m_wom_we = 1'b1;
                    m_waddr  = beats[0].addr;
                    m_wdata  = beats[0].data;
                end else begin
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", bus.in_ready, m_in_ready);
            chk("we_pxl", bus.we_pxl, m_we_pxl);
            chk("wr_pos_pxl", bus.wr_pos_pxl, m_pos_pxl);
            chk("wdp1", bus.wdp1, m_wdp[0]);
            chk("wdp2", bus.wdp2, m_wdp[1]);
            chk("wdp3", bus.wdp3, m_wdp[2]);
            chk("wdp4", bus.wdp4, m_wdp[3]);
            chk("we_mul", bus.we_mul, m_we_mul);
            chk("wr_mul_pos_in", bus.wr_mul_pos_in, m_pos_mul);
            chk("wdm1", bus.wdm1, m_wdm[0]);
            chk("wdm2", bus.wdm2, m_wdm[1]);
            chk("wdm3", bus.wdm3, m_wdm[2]);
            chk("wdm4", bus.wdm4, m_wdm[3]);
            chk("wom_we", bus.wom_we, m_wom_we);
            chk("wom_waddr", bus.wom_waddr, m_waddr);
            chk("wom_wdata", 32'(bus.wom_wdata), 32'(m_wdata));
            chk("done", bus.done, m_done);
        end
    end

    task automatic step();
        @(negedge clk);
        if (rand_mode)
            bus.wom_ready = ($urandom % 4) != 0;
    endtask

    // Offers a bundle and returns on the negedge right after the accepting edge.
    task automatic send(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3,
                        input logic [31:0] r4, input logic pxl, input logic mul, input logic pos,
                        input logic mpos, input logic wom, input logic [31:0] base);
        int n;
        bus.res1 = r1; bus.res2 = r2; bus.res3 = r3; bus.res4 = r4;
        bus.wr_pxl = pxl; bus.wr_mul_reg = mul; bus.wr_pos = pos; bus.wr_mul_pos = mpos;
        bus.wr_wom = wom; bus.wom_addr = base;
        bus.valid_in = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!m_accepted && n < 500);
        if (!m_accepted) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: actual not accepted required accepted within 500 cycles");
        end
        bus.valid_in = 1'b0;
    endtask

    function automatic logic [31:0] rand_res();
        case ($urandom % 3)
            0:       return $urandom;
            1:       return $urandom_range(0, 300);
            default: return 32'(-$signed($urandom_range(1, 1000)));
        endcase
    endfunction

    initial begin
        logic [7:0] exp_d [4];
        exp_d = '{8'd0, 8'd255, 8'd128, 8'd255};
        bus.valid_in = 1'b0;
        {bus.wr_pxl, bus.wr_mul_reg, bus.wr_pos, bus.wr_mul_pos, bus.wr_wom} = '0;
        {bus.res1, bus.res2, bus.res3, bus.res4} = '0;
        bus.wom_addr = '0;
        bus.wom_ready = 1'b1;
        rst = 1'b1;
        repeat (2) step();
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_wom_we", bus.wom_we, 1'b0);
        rst = 1'b0;
        step();

        send(32'd15, 32'd16, 32'd17, 32'd18, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t1_we_pxl", bus.we_pxl, 1'b1);
        chk("t1_wdp1", bus.wdp1, 32'd15);
        chk("t1_wdp4", bus.wdp4, 32'd18);
        chk("t1_done", bus.done, 1'b1);
        chk("t1_we_mul", bus.we_mul, 1'b0);
        step();
        chk("t1_in_ready_back", bus.in_ready, 1'b1);

        send(32'd150, 32'd160, 32'd170, 32'd180, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t2_we_pxl", bus.we_pxl, 1'b1);
        chk("t2_we_mul", bus.we_mul, 1'b1);
        chk("t2_wdm1", bus.wdm1, 32'd150);
        chk("t2_wdm4", bus.wdm4, 32'd180);
        chk("t2_pos_pxl", bus.wr_pos_pxl, 1'b1);
        chk("t2_pos_mul", bus.wr_mul_pos_in, 1'b1);

        send(32'hFFFF_FFFB, 32'd300, 32'd128, 32'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        for (int k = 0; k < 4; k++) begin
            chk("t3_addr", bus.wom_waddr, 32'h100 + 32'(k));
            chk("t3_data", 32'(bus.wom_wdata), 32'(exp_d[k]));
            chk("t3_we", bus.wom_we, 1'b1);
            step();
        end
        chk("t3_done", bus.done, 1'b1);
        chk("t3_in_ready", bus.in_ready, 1'b1);

        send(32'hFFFF_FFFB, 32'd300, 32'd128, 32'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        step();
        bus.wom_ready = 1'b0;
        bus.res1 = 32'd7; bus.wr_wom = 1'b0; bus.wr_pxl = 1'b1;
        bus.valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_hold_addr", bus.wom_waddr, 32'h101);
            chk("t4_hold_data", 32'(bus.wom_wdata), 32'd255);
            chk("t4_in_ready", bus.in_ready, 1'b0);
        end
        bus.valid_in = 1'b0;
        bus.wom_ready = 1'b1;
        repeat (3) step();
        chk("t4_done", bus.done, 1'b1);

        send(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        chk("t5_addr0", bus.wom_waddr, 32'hFFFF_FFFE);
        step();
        chk("t5_addr1", bus.wom_waddr, 32'hFFFF_FFFF);
        step();
        chk("t5_addr2", bus.wom_waddr, 32'h0);
        step();
        chk("t5_addr3", bus.wom_waddr, 32'h1);
        step();

        send(32'd9, 32'd8, 32'd7, 32'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_done", bus.done, 1'b0);
        chk("t6_wom_we", bus.wom_we, 1'b0);
        chk("t6_waddr", bus.wom_waddr, 32'h0);
        chk("t6_in_ready", bus.in_ready, 1'b1);
        send(32'd21, 32'd22, 32'd23, 32'd24, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("t6_new_done", bus.done, 1'b1);
        chk("t6_new_wdm2", bus.wdm2, 32'd22);

        rand_mode = 1'b1;
        repeat (300) begin
            logic [4:0] f;
            repeat ($urandom % 3) step();
            f = 5'($urandom);
            send(rand_res(), rand_res(), rand_res(), rand_res(),
                 f[0], f[1], f[2], f[3], f[4], $urandom);
        end
        rand_mode = 1'b0;
        bus.wom_ready = 1'b1;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
